// File: rtl/rr_mux_arbiter_if.sv
// Handshake bundle between the requesters/consumer and rr_mux_arbiter.
// The arbiter uses the slave modport; the requester/consumer side uses master.
interface rr_mux_arbiter_if #(
    parameter int N = 2
);
    localparam int R = 1 << N;

    logic [R-1:0] req;
    logic         ready_i;
    logic [R-1:0] gnt;
    logic [N-1:0] s;
    logic         valid_o;
    logic [R-1:0] ack;
    logic         busy;

    modport slave (
        input  req,
        input  ready_i,
        output gnt,
        output s,
        output valid_o,
        output ack,
        output busy
    );

    modport master (
        output req,
        output ready_i,
        input  gnt,
        input  s,
        input  valid_o,
        input  ack,
        input  busy
    );
endinterface

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter driving the select of a shared mux_n plus a valid/ready handshake.
// Define RR_HOLD_EN to let a granted requester keep the path for up to MAX_BURST transfers.
module rr_mux_arbiter #(
    parameter int N         = 2,
    parameter int MAX_BURST = 4
) (
    input  logic            clk,
    input  logic            rst,
    rr_mux_arbiter_if.slave bus
);
    localparam int R = 1 << N;

    typedef enum logic {IDLE, GRANT} state_t;

    state_t       r_state, w_state_nxt;
    logic [R-1:0] r_gnt, w_gnt_nxt;
    logic [N-1:0] r_s, w_s_nxt;
    logic [N-1:0] r_ptr, w_ptr_nxt;
    logic         r_valid, w_valid_nxt;
    logic [N-1:0] w_ptr_adv;
    logic [R-1:0] w_cand;
    logic [N-1:0] w_win;
    logic         w_hold;

    // First set bit of mask, scanning upward from start and wrapping mod R.
    function automatic logic [N-1:0] f_pick(input logic [R-1:0] mask, input logic [N-1:0] start);
        logic [N-1:0] idx;
        logic         found;
        f_pick = start;
        found  = 1'b0;
        for (int i = 0; i < R; i++) begin
            idx = start + N'(i);
            if (!found && mask[idx]) begin
                f_pick = idx;
                found  = 1'b1;
            end
        end
    endfunction

    assign w_ptr_adv = r_s + N'(1);

`ifdef RR_HOLD_EN
    logic [7:0] r_burst, w_burst_nxt;

    assign w_hold = bus.req[r_s] && ((r_burst + 8'd1) < 8'(MAX_BURST));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_burst <= 8'd0;
        else     r_burst <= w_burst_nxt;
    end
`else
    assign w_hold = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_gnt   <= '0;
            r_s     <= '0;
            r_ptr   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_s     <= w_s_nxt;
            r_ptr   <= w_ptr_nxt;
            r_valid <= w_valid_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_s_nxt     = r_s;
        w_ptr_nxt   = r_ptr;
        w_valid_nxt = r_valid;
        w_cand      = '0;
        w_win       = '0;
`ifdef RR_HOLD_EN
        w_burst_nxt = r_burst;
`endif
        case (r_state)
            IDLE: begin
                if (|bus.req) begin
                    w_win       = f_pick(bus.req, r_ptr);
                    w_gnt_nxt   = R'(1) << w_win;
                    w_s_nxt     = w_win;
                    w_valid_nxt = 1'b1;
                    w_state_nxt = GRANT;
`ifdef RR_HOLD_EN
                    w_burst_nxt = 8'd0;
`endif
                end
            end
            GRANT: begin
                // A requester dropping out before its ack forfeits the grant; ptr stays put.
                if (!bus.req[r_s]) begin
                    w_gnt_nxt   = '0;
                    w_valid_nxt = 1'b0;
                    w_state_nxt = IDLE;
`ifdef RR_HOLD_EN
                    w_burst_nxt = 8'd0;
`endif
                end else if (bus.ready_i) begin
                    if (w_hold) begin
`ifdef RR_HOLD_EN
                        w_burst_nxt = r_burst + 8'd1;
`endif
                    end else begin
                        w_ptr_nxt = w_ptr_adv;
                        w_cand    = bus.req & ~r_gnt;
`ifdef RR_HOLD_EN
                        w_burst_nxt = 8'd0;
`endif
                        // Re-arbitrate immediately so a different requester follows with no bubble.
                        if (|w_cand) begin
                            w_win     = f_pick(w_cand, w_ptr_adv);
                            w_gnt_nxt = R'(1) << w_win;
                            w_s_nxt   = w_win;
                        end else begin
                            w_gnt_nxt   = '0;
                            w_valid_nxt = 1'b0;
                            w_state_nxt = IDLE;
                        end
                    end
                end
            end
            default: begin
                w_gnt_nxt   = '0;
                w_valid_nxt = 1'b0;
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign bus.gnt     = r_gnt;
    assign bus.s       = r_s;
    assign bus.valid_o = r_valid;
    assign bus.busy    = r_valid;
    assign bus.ack     = r_gnt & {R{r_valid & bus.ready_i}};
endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Self-checking bench for rr_mux_arbiter: cycle-vector table plus scoreboarded grant sequences.
module tb_rr_mux_arbiter;
  localparam int N  = 2;
  localparam int R  = 4;
  localparam int MB = 4;
`ifdef RR_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rr_mux_arbiter_if #(.N(N)) bus ();
  rr_mux_arbiter #(.N(N), .MAX_BURST(MB)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    logic [3:0] req;
    logic       rdy;
    logic [3:0] gnt;
    logic [1:0] s;
    logic       vld;
    logic [3:0] ack;
  } vec_t;

  vec_t tbl[$];
  int   sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic add(input logic [3:0] rq, input logic rd, input logic [3:0] g,
                     input logic [1:0] sx, input logic v, input logic [3:0] a);
    vec_t t;
    t.req = rq; t.rdy = rd; t.gnt = g; t.s = sx; t.vld = v; t.ack = a;
    tbl.push_back(t);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    bus.req = '0;
    bus.ready_i = 1'b0;
    @(negedge clk);
    #1;
    chk({tag, "_rst_gnt"}, 32'(bus.gnt), 32'd0);
    chk({tag, "_rst_vld"}, 32'(bus.valid_o), 32'd0);
    chk({tag, "_rst_s"}, 32'(bus.s), 32'd0);
    chk({tag, "_rst_ack"}, 32'(bus.ack), 32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] last_ack;
    int         e;
    bit         started;

    bus.req = '0;
    bus.ready_i = 1'b0;
    do_reset("init");
    chk("init_busy", 32'(bus.busy), 32'd0);

`ifndef RR_HOLD_EN
    // req, rdy | gnt, s, valid, ack  (outputs observed in the same cycle the inputs are applied)
    add(4'b0000, 0, 4'b0000, 0, 0, 4'b0000);
    add(4'b0010, 0, 4'b0000, 0, 0, 4'b0000);
    add(4'b0010, 0, 4'b0010, 1, 1, 4'b0000);
    add(4'b0010, 1, 4'b0010, 1, 1, 4'b0010);
    add(4'b0000, 1, 4'b0000, 1, 0, 4'b0000);
    add(4'b1001, 1, 4'b0000, 1, 0, 4'b0000);
    add(4'b1001, 1, 4'b1000, 3, 1, 4'b1000);
    add(4'b0001, 1, 4'b0001, 0, 1, 4'b0001);
    add(4'b0100, 0, 4'b0000, 0, 0, 4'b0000);
    add(4'b0100, 1, 4'b0100, 2, 1, 4'b0100);
    add(4'b1010, 0, 4'b0000, 2, 0, 4'b0000);
    add(4'b1010, 0, 4'b1000, 3, 1, 4'b0000);
    add(4'b1010, 1, 4'b1000, 3, 1, 4'b1000);
    add(4'b0010, 1, 4'b0010, 1, 1, 4'b0010);
    add(4'b0001, 0, 4'b0000, 1, 0, 4'b0000);
    add(4'b0001, 1, 4'b0001, 0, 1, 4'b0001);
    add(4'b0010, 0, 4'b0000, 0, 0, 4'b0000);
    add(4'b0010, 0, 4'b0010, 1, 1, 4'b0000);
    add(4'b0000, 0, 4'b0010, 1, 1, 4'b0000);
    add(4'b0011, 0, 4'b0000, 1, 0, 4'b0000);
    add(4'b0011, 1, 4'b0010, 1, 1, 4'b0010);
    add(4'b0001, 1, 4'b0001, 0, 1, 4'b0001);
    add(4'b0100, 0, 4'b0000, 0, 0, 4'b0000);
    add(4'b0000, 1, 4'b0100, 2, 1, 4'b0100);
    add(4'b0101, 0, 4'b0000, 2, 0, 4'b0000);
    add(4'b0101, 1, 4'b0100, 2, 1, 4'b0100);
    add(4'b0001, 0, 4'b0001, 0, 1, 4'b0000);
    add(4'b0001, 1, 4'b0001, 0, 1, 4'b0001);
    add(4'b0000, 0, 4'b0000, 0, 0, 4'b0000);

    foreach (tbl[i]) begin
      @(negedge clk);
      bus.req = tbl[i].req;
      bus.ready_i = tbl[i].rdy;
      #1;
      chk($sformatf("v%0d_gnt", i), 32'(bus.gnt), 32'(tbl[i].gnt));
      chk($sformatf("v%0d_s", i), 32'(bus.s), 32'(tbl[i].s));
      chk($sformatf("v%0d_vld", i), 32'(bus.valid_o), 32'(tbl[i].vld));
      chk($sformatf("v%0d_busy", i), 32'(bus.busy), 32'(tbl[i].vld));
      chk($sformatf("v%0d_ack", i), 32'(bus.ack), 32'(tbl[i].ack));
    end
`endif

    // Reset asserted while requester 2 holds the grant
    do_reset("mid");
    @(negedge clk);
    bus.req = 4'b0100;
    @(negedge clk);
    #1;
    chk("mid_pre_gnt", 32'(bus.gnt), 32'(4'b0100));
    chk("mid_pre_s", 32'(bus.s), 32'd2);
    rst = 1'b1;
    #1;
    chk("mid_gnt", 32'(bus.gnt), 32'd0);
    chk("mid_vld", 32'(bus.valid_o), 32'd0);
    chk("mid_s", 32'(bus.s), 32'd0);
    chk("mid_ack", 32'(bus.ack), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    bus.req = 4'b0001;
    @(posedge clk);
    #1;
    chk("mid_after_gnt", 32'(bus.gnt), 32'(4'b0001));
    chk("mid_after_vld", 32'(bus.valid_o), 32'd1);
    @(negedge clk);
    bus.req = '0;
    @(negedge clk);

    // Backpressure on a single requester
    do_reset("bp");
    @(negedge clk);
    bus.req = 4'b0010;
    bus.ready_i = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1;
      chk($sformatf("bp%0d_gnt", c), 32'(bus.gnt), 32'(4'b0010));
      chk($sformatf("bp%0d_s", c), 32'(bus.s), 32'd1);
      chk($sformatf("bp%0d_ack", c), 32'(bus.ack), 32'd0);
    end
    @(negedge clk);
    bus.ready_i = 1'b1;
    #1;
    chk("bp_accept_ack", 32'(bus.ack), 32'(4'b0010));
    @(negedge clk);
    bus.req = '0;
    bus.ready_i = 1'b0;
    #1;
    chk("bp_after_gnt", 32'(bus.gnt), HOLD ? 32'(4'b0010) : 32'd0);
    chk("bp_after_vld", 32'(bus.valid_o), HOLD ? 32'd1 : 32'd0);
    @(negedge clk);
    @(negedge clk);

`ifndef RR_HOLD_EN
    // Full contention: each requester drops for one cycle after its ack, then re-requests
    do_reset("cont");
    for (int k = 0; k < 8; k++) sb.push_back(k % R);
    bus.ready_i = 1'b1;
    last_ack = '0;
    started = 1'b0;
    for (int c = 0; c < 40 && sb.size() > 0; c++) begin
      @(negedge clk);
      bus.req = 4'b1111 & ~last_ack;
      #1;
      if (started) chk($sformatf("cont%0d_vld", c), 32'(bus.valid_o), 32'd1);
      last_ack = bus.ack;
      if (bus.valid_o) begin
        started = 1'b1;
        e = sb.pop_front();
        chk($sformatf("cont%0d_s", c), 32'(bus.s), 32'(e));
        chk($sformatf("cont%0d_ack", c), 32'(bus.ack), 32'(1 << e));
      end
    end
    chk("cont_drain", 32'(sb.size()), 32'd0);
    @(negedge clk);
    bus.req = '0;
    bus.ready_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
`endif

    // Two requesters held high: alternate per accept, or bursts of MB with hold enabled
    do_reset("alt");
    sb.delete();
    for (int k = 0; k < 12; k++) sb.push_back(HOLD ? ((k / MB) % 2) : (k % 2));
    bus.req = 4'b0011;
    bus.ready_i = 1'b1;
    for (int c = 0; c < 40 && sb.size() > 0; c++) begin
      @(negedge clk);
      #1;
      if (bus.valid_o && bus.ready_i) begin
        e = sb.pop_front();
        chk($sformatf("alt%0d_s", c), 32'(bus.s), 32'(e));
        chk($sformatf("alt%0d_ack", c), 32'(bus.ack), 32'(1 << e));
      end
    end
    chk("alt_drain", 32'(sb.size()), 32'd0);
    bus.req = '0;
    bus.ready_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("final_idle_vld", 32'(bus.valid_o), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/rr_mux_arbiter.md
Name: rr_mux_arbiter

Overview:
- Round-robin arbiter that shares one mux_n output path among 2**N requesters.
- Drives the mux select `s` and a one-hot grant, and presents a valid/ready handshake to the single downstream consumer.
- Sits directly in front of mux_n: `s` connects to mux_n `.s`; requester data goes to mux_n `.a`.

Parameters:
- N, 2, select width; number of requesters R = 2**N.
- MAX_BURST, 4, maximum consecutive accepted transfers per grant; used only when RR_HOLD_EN is defined; legal range 1..255.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  R  request per requester; must stay high until that requester sees its ack bit.
- ready_i  input  1  downstream accepts the current transfer.
- gnt  output  R  registered one-hot grant, all-zero when idle.
- s  output  N  registered mux select, equal to index of the set gnt bit; holds last value when idle.
- valid_o  output  1  registered; high while a grant is active.
- ack  output  R  combinational: gnt & {R{valid_o & ready_i}}.
- busy  output  1  equals valid_o.

Behaviour:
- Reset (async, immediate), also mid-transfer: state=IDLE, gnt=0, s=0, valid_o=0, ack=0, round-robin pointer ptr=0, burst count=0.
- Priority rule: winner = first index i scanning ptr, ptr+1, … wrapping mod R, with the candidate mask bit set.
- IDLE:
  - If |req, register winner over req: gnt=onehot(winner), s=winner, valid_o=1, go GRANT.
  - Latency: req rising edge seen at edge k → gnt/valid_o high after edge k.
  - Otherwise stay IDLE.
- GRANT, valid_o & ready_i (accept), without hold:
  - ptr <= s+1 mod R; wrap from R-1 to 0.
  - Re-arbitrate in the same cycle over req & ~gnt.
  - If any candidate exists, load the new winner with no bubble, so back-to-back transfers among different requesters run one per cycle.
  - Otherwise gnt=0, valid_o=0, go IDLE.
  - The same requester is never granted on two consecutive cycles without an intervening IDLE cycle.
- GRANT, ready_i low:
  - Hold gnt, s and valid_o unchanged, regardless of other requests.
- GRANT, req[s] deasserted before ack (protocol violation):
  - At the next edge go IDLE, gnt=0, valid_o=0, ptr unchanged.
  - ready_i in that cycle is still acked; ack is combinational.
- Simultaneous requests with ptr=0 and req=4'b1111: grant order 0,1,2,3,0…
- Fairness: a continuously requesting input waits at most R-1 accepted transfers before its grant.

Optional Feature:
- Macro RR_HOLD_EN.
- Defined:
  - On accept, if req[s] is still high and burst count+1 < MAX_BURST, keep the grant (burst count++) and do not advance ptr.
  - Otherwise behave as the base accept rule and clear burst count.
  - Burst count resets to 0 on every new grant.
- Undefined: burst count logic absent; exactly one transfer per grant; MAX_BURST ignored.

Test Plan:
- Reset mid-grant: req=4'b0100, granted, assert rst with ready_i=0 → same-cycle gnt=0, valid_o=0, s=0; after release and req=4'b0001, gnt=4'b0001 one edge later.
- Full contention, ready_i=1 constant, req=4'b1111 held (each bit dropping one cycle after its ack, then reasserting) → s sequence 0,1,2,3,0 with valid_o high every cycle.
- Backpressure: req=4'b0010, ready_i=0 for 5 cycles → gnt=4'b0010, s=1 stable, ack=0; ready_i=1 → ack=4'b0010 that cycle; next cycle gnt=0, valid_o=0.
- Pointer wrap: after a grant to 3 is accepted, req=4'b1001 → next grant is 0, not 3; with req=4'b1010 after a grant to 2 → next grant is 3.
- Abandon: granted requester 1, req[1] drops with ready_i=0 → next edge IDLE, ack never pulses; next req=4'b0011 grants 1 first (ptr unchanged).
- RR_HOLD_EN with MAX_BURST=4: req=4'b0011 held, ready_i=1 → s=0 for 4 accepts, then s=1 for 4 accepts; same bench without the macro → s alternates 0,1 every accept.
